// File: rtl/mc_residual_stream_pkg.sv
// Shared widths, types and lane-slicing helpers for the residual streaming slice.
package mc_pkg;

  localparam int PIXEL_WIDTH_DEFAULT = 8;

  function automatic int res_width(input int pw);
    return pw + 1;
  endfunction

  function automatic int sad_width(input int pw, input int lanes, input int beats);
    return pw + $clog2(lanes * beats) + 1;
  endfunction

  typedef logic [PIXEL_WIDTH_DEFAULT-1:0] pixel_t;
  typedef logic signed [PIXEL_WIDTH_DEFAULT:0] residual_t;

  // Bit offset of a lane inside a packed row.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mc_residual_stream_if.sv
// Source/destination beat bundle for mc_residual_stream.
interface mc_residual_stream_if #(
  parameter int LANES        = 4,
  parameter int PIXEL_WIDTH  = 8,
  parameter int BEATS_PER_MB = 4
);
  import mc_pkg::*;

  localparam int RES_WIDTH = res_width(PIXEL_WIDTH);
  localparam int SAD_WIDTH = sad_width(PIXEL_WIDTH, LANES, BEATS_PER_MB);

  logic                         src_valid;
  logic                         src_ready;
  logic                         src_bipred;
  logic [LANES*PIXEL_WIDTH-1:0] src_ref0;
  logic [LANES*PIXEL_WIDTH-1:0] src_ref1;
  logic [LANES*PIXEL_WIDTH-1:0] src_cur;

  logic                         dst_valid;
  logic                         dst_ready;
  logic [LANES*RES_WIDTH-1:0]   dst_residual;
  logic                         dst_last;
  logic [SAD_WIDTH-1:0]         dst_sad;
  logic                         dst_zero;

  modport master (
    output src_valid, src_bipred, src_ref0, src_ref1, src_cur, dst_ready,
    input  src_ready, dst_valid, dst_residual, dst_last, dst_sad, dst_zero
  );

  modport slave (
    input  src_valid, src_bipred, src_ref0, src_ref1, src_cur, dst_ready,
    output src_ready, dst_valid, dst_residual, dst_last, dst_sad, dst_zero
  );

endinterface

// File: rtl/mc_residual_stream_lane.sv
// One lane: prediction and signed residual (S1 side), magnitude of a registered residual (S2 side).
module mc_lane_residual #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] ref0,
  input  logic [PIXEL_WIDTH-1:0] ref1,
  input  logic [PIXEL_WIDTH-1:0] cur,
  input  logic                   bipred,
  output logic [PIXEL_WIDTH:0]   residual,
  input  logic [PIXEL_WIDTH:0]   res_in,
  output logic [PIXEL_WIDTH-1:0] abs_out
);

  logic [PIXEL_WIDTH:0]   sum;
  logic [PIXEL_WIDTH-1:0] pred;

  always_comb begin
    sum      = {1'b0, ref0} + {1'b0, ref1} + (PIXEL_WIDTH+1)'(1);
    pred     = bipred ? PIXEL_WIDTH'(sum >> 1) : ref0;
    residual = {1'b0, cur} - {1'b0, pred};
    // Magnitude never exceeds 2^PW-1, so the low PW bits of the negation are exact.
    abs_out  = res_in[PIXEL_WIDTH] ? (~res_in[PIXEL_WIDTH-1:0] + PIXEL_WIDTH'(1))
                                   : res_in[PIXEL_WIDTH-1:0];
  end

endmodule

// File: rtl/mc_residual_stream.sv
// Two-stage residual pipeline: S1 predicts/subtracts, S2 accumulates SAD and zero flag per macroblock.
module mc_residual_stream
  import mc_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int PIXEL_WIDTH  = PIXEL_WIDTH_DEFAULT,
  parameter int BEATS_PER_MB = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_residual_stream_if.slave  bus
);

  localparam int RES_WIDTH = res_width(PIXEL_WIDTH);
  localparam int SAD_WIDTH = sad_width(PIXEL_WIDTH, LANES, BEATS_PER_MB);
  localparam int CNT_W     = (BEATS_PER_MB > 1) ? $clog2(BEATS_PER_MB) : 1;

  logic [CNT_W-1:0]             beat_cnt;
  logic                         mode_q;
  logic                         rdy_en;
  logic                         s1_valid, s2_valid;
  logic [LANES*RES_WIDTH-1:0]   s1_res;
  logic                         s1_last;
  logic [SAD_WIDTH-1:0]         acc_sad;
  logic                         acc_zero;

  logic                         s1_ready, s2_ready, src_fire, s1_fire;
  logic                         is_beat0, is_last, eff_bipred;
  logic [LANES*RES_WIDTH-1:0]   comb_res;
  logic [LANES*PIXEL_WIDTH-1:0] abs_v;
  logic [SAD_WIDTH-1:0]         beat_sad;
  logic                         beat_zero;

  assign s2_ready      = !s2_valid || bus.dst_ready;
  assign s1_ready      = !s1_valid || s2_ready;
  assign bus.src_ready = rdy_en && s1_ready;
  assign src_fire      = bus.src_valid && bus.src_ready;
  assign s1_fire       = s1_valid && s2_ready;
  assign bus.dst_valid = s2_valid;

  assign is_beat0   = (beat_cnt == '0);
  assign is_last    = (beat_cnt == CNT_W'(BEATS_PER_MB - 1));
  // Beat 0 uses the live mode bit; later beats reuse the value latched on beat 0.
  assign eff_bipred = is_beat0 ? bus.src_bipred : mode_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mc_lane_residual #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_lane (
      .ref0     (bus.src_ref0[lane_lsb(g, PIXEL_WIDTH) +: PIXEL_WIDTH]),
      .ref1     (bus.src_ref1[lane_lsb(g, PIXEL_WIDTH) +: PIXEL_WIDTH]),
      .cur      (bus.src_cur[lane_lsb(g, PIXEL_WIDTH) +: PIXEL_WIDTH]),
      .bipred   (eff_bipred),
      .residual (comb_res[lane_lsb(g, RES_WIDTH) +: RES_WIDTH]),
      .res_in   (s1_res[lane_lsb(g, RES_WIDTH) +: RES_WIDTH]),
      .abs_out  (abs_v[lane_lsb(g, PIXEL_WIDTH) +: PIXEL_WIDTH])
    );
  end

  always_comb begin
    beat_sad  = '0;
    beat_zero = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      beat_sad  = beat_sad + SAD_WIDTH'(abs_v[lane_lsb(i, PIXEL_WIDTH) +: PIXEL_WIDTH]);
      beat_zero = beat_zero && (s1_res[lane_lsb(i, RES_WIDTH) +: RES_WIDTH] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en   <= 1'b0;
      beat_cnt <= '0;
      mode_q   <= 1'b0;
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_last  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (s1_ready) s1_valid <= src_fire;
      if (src_fire) begin
        s1_res   <= comb_res;
        s1_last  <= is_last;
        beat_cnt <= is_last ? '0 : beat_cnt + CNT_W'(1);
        if (is_beat0) mode_q <= bus.src_bipred;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid         <= 1'b0;
      acc_sad          <= '0;
      acc_zero         <= 1'b1;
      bus.dst_residual <= '0;
      bus.dst_last     <= 1'b0;
      bus.dst_sad      <= '0;
      bus.dst_zero     <= 1'b0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_fire) begin
        bus.dst_residual <= s1_res;
        bus.dst_last     <= s1_last;
        if (s1_last) begin
          bus.dst_sad  <= acc_sad + beat_sad;
          bus.dst_zero <= acc_zero && beat_zero;
          acc_sad      <= '0;
          acc_zero     <= 1'b1;
        end else begin
          bus.dst_sad  <= '0;
          bus.dst_zero <= 1'b0;
          acc_sad      <= acc_sad + beat_sad;
          acc_zero     <= acc_zero && beat_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_residual_stream.sv
// Scoreboard bench for mc_residual_stream: directed macroblocks, backpressure, back-to-back and reset.
module tb_mc_residual_stream;

  localparam int L  = 4;
  localparam int PW = 8;
  localparam int B  = 4;
  localparam int RW = PW + 1;
  localparam int SW = PW + $clog2(L * B) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_residual_stream_if #(.LANES(L), .PIXEL_WIDTH(PW), .BEATS_PER_MB(B)) bus ();

  mc_residual_stream #(.LANES(L), .PIXEL_WIDTH(PW), .BEATS_PER_MB(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [L*RW-1:0] res;
    logic            last;
    logic [SW-1:0]   sad;
    logic            zero;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   outs = 0;
  int   first_acc_cyc = -1;
  int   first_out_cyc = -1;
  int   last_out_cyc = 0;
  bit   prod_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [L*PW-1:0] pix4(input int a, input int b, input int c, input int d);
    logic [L*PW-1:0] r;
    r[0*PW +: PW] = PW'(a);
    r[1*PW +: PW] = PW'(b);
    r[2*PW +: PW] = PW'(c);
    r[3*PW +: PW] = PW'(d);
    return r;
  endfunction

  function automatic logic [L*RW-1:0] res4(input int a, input int b, input int c, input int d);
    logic [L*RW-1:0] r;
    r[0*RW +: RW] = RW'(a);
    r[1*RW +: RW] = RW'(b);
    r[2*RW +: RW] = RW'(c);
    r[3*RW +: RW] = RW'(d);
    return r;
  endfunction

  // Monitor: counts handshakes and checks every delivered beat against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.src_valid && bus.src_ready) begin
        accepts++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (bus.dst_valid && bus.dst_ready) begin
        outs++;
        last_out_cyc = cyc;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got residual %0h with no expectation queued", bus.dst_residual);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("residual", bus.dst_residual, e.res);
          check("last", bus.dst_last, e.last);
          check("sad", bus.dst_sad, e.sad);
          check("zero", bus.dst_zero, e.zero);
        end
      end
    end
  end

  task automatic send_beat(input logic [L*PW-1:0] r0, input logic [L*PW-1:0] r1,
                           input logic [L*PW-1:0] cur, input logic bp,
                           input logic [L*RW-1:0] er, input logic el, input int esad,
                           input logic ez, input bit keep_valid, input bit push);
    exp_t e;
    int n;
    e.res = er; e.last = el; e.sad = SW'(esad); e.zero = ez;
    if (push) sb.push_back(e);
    bus.src_ref0   = r0;
    bus.src_ref1   = r1;
    bus.src_cur    = cur;
    bus.src_bipred = bp;
    bus.src_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.src_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.src_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: src_ready stayed %0b, required 1", bus.src_ready);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) bus.src_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Four-beat macroblock with identical rows; the last beat carries the macroblock totals.
  task automatic send_mb(input logic [L*PW-1:0] r0, input logic [L*PW-1:0] r1,
                         input logic [L*PW-1:0] cur, input logic bp0, input logic bp_rest,
                         input logic [L*RW-1:0] er, input int esad, input logic ez,
                         input bit keep_after);
    for (int i = 0; i < B; i++)
      send_beat(r0, r1, cur, (i == 0) ? bp0 : bp_rest, er, (i == B - 1),
                (i == B - 1) ? esad : 0, (i == B - 1) ? ez : 1'b0,
                (i < B - 1) || keep_after, 1'b1);
  endtask

  initial begin
    int base;
    int n;
    logic [L*RW-1:0] cap_res;
    logic            cap_last;
    logic [SW-1:0]   cap_sad;

    bus.src_valid  = 1'b0;
    bus.src_bipred = 1'b0;
    bus.src_ref0   = '0;
    bus.src_ref1   = '0;
    bus.src_cur    = '0;
    bus.dst_ready  = 1'b1;
    reset          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_dst_valid", bus.dst_valid, 0);
    check("rst_residual", bus.dst_residual, 0);
    check("rst_sad", bus.dst_sad, 0);
    check("rst_last", bus.dst_last, 0);
    check("rst_zero", bus.dst_zero, 0);
    check("rst_src_ready", bus.src_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("src_ready_before_edge", bus.src_ready, 0);
    @(posedge clk);
    #1;
    check("src_ready_after_edge", bus.src_ready, 1);

    // 1: single reference, residual {5,7,4,8}, SAD 4*24.
    first_acc_cyc = -1;
    first_out_cyc = -1;
    send_mb(pix4(55, 23, 1, 2), pix4(0, 0, 0, 0), pix4(60, 30, 5, 10), 1'b0, 1'b0,
            res4(5, 7, 4, 8), 96, 1'b0, 1'b0);
    wait_drain();
    check("latency", first_out_cyc - first_acc_cyc, 2);

    // 2: extremes, residual -255 per lane, SAD 16*255.
    send_mb(pix4(255, 255, 255, 255), pix4(0, 0, 0, 0), pix4(0, 0, 0, 0), 1'b0, 1'b0,
            res4(-255, -255, -255, -255), 4080, 1'b0, 1'b0);
    wait_drain();

    // 3: bipred latched on beat 0; (10+13+1)>>1 = 12 so every residual is 0.
    send_mb(pix4(10, 10, 10, 10), pix4(13, 13, 13, 13), pix4(12, 12, 12, 12), 1'b1, 1'b0,
            res4(0, 0, 0, 0), 0, 1'b1, 1'b0);
    wait_drain();

    // 4: backpressure with continuous src_valid.
    bus.dst_ready = 1'b0;
    base = accepts;
    prod_done = 1'b0;
    fork
      begin
        send_mb(pix4(100, 100, 100, 100), pix4(0, 0, 0, 0), pix4(103, 103, 103, 103),
                1'b0, 1'b0, res4(3, 3, 3, 3), 48, 1'b0, 1'b0);
        prod_done = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    cap_res  = bus.dst_residual;
    cap_last = bus.dst_last;
    cap_sad  = bus.dst_sad;
    repeat (2) @(negedge clk);
    check("stall_accepts", accepts - base, 2);
    check("stall_src_ready", bus.src_ready, 0);
    check("stall_dst_valid", bus.dst_valid, 1);
    check("stall_residual_hold", bus.dst_residual, cap_res);
    check("stall_residual_value", bus.dst_residual, res4(3, 3, 3, 3));
    check("stall_last_hold", {bus.dst_last, bus.dst_sad}, {cap_last, cap_sad});
    @(posedge clk);
    #1;
    bus.dst_ready = 1'b1;
    n = 0;
    while (!prod_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stall_producer_done", prod_done, 1);
    wait_drain();

    // 5: back-to-back macroblocks, residual 1 then 0, no bubble.
    base = outs;
    first_out_cyc = -1;
    send_mb(pix4(40, 41, 42, 43), pix4(0, 0, 0, 0), pix4(41, 42, 43, 44), 1'b0, 1'b0,
            res4(1, 1, 1, 1), 16, 1'b0, 1'b1);
    send_mb(pix4(40, 41, 42, 43), pix4(0, 0, 0, 0), pix4(40, 41, 42, 43), 1'b0, 1'b0,
            res4(0, 0, 0, 0), 0, 1'b1, 1'b0);
    wait_drain();
    check("b2b_outputs", outs - base, 8);
    check("b2b_no_bubble", last_out_cyc - first_out_cyc, 7);

    // 6: reset mid-macroblock discards the two buffered beats.
    bus.dst_ready = 1'b0;
    send_beat(pix4(0, 0, 0, 0), pix4(0, 0, 0, 0), pix4(9, 9, 9, 9), 1'b0,
              res4(9, 9, 9, 9), 1'b0, 0, 1'b0, 1'b1, 1'b0);
    send_beat(pix4(0, 0, 0, 0), pix4(0, 0, 0, 0), pix4(9, 9, 9, 9), 1'b0,
              res4(9, 9, 9, 9), 1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_dst_valid", bus.dst_valid, 0);
    check("midrst_residual", bus.dst_residual, 0);
    check("midrst_src_ready", bus.src_ready, 0);
    bus.dst_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_mb(pix4(20, 20, 20, 20), pix4(0, 0, 0, 0), pix4(22, 22, 22, 22), 1'b0, 1'b0,
            res4(2, 2, 2, 2), 32, 1'b0, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
